// File: rtl/match_controller.sv
// Match sequencing for a two-player paddle game: start-edge detection, serve countdown,
// point scoring with saturation, let handling, win detection and abort-to-idle.
`timescale 1ns/1ps
module match_controller #(
  parameter int WIN_SCORE   = 10,
  parameter int SERVE_DELAY = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       game_tick,
  input  logic       point_left,
  input  logic       point_right,
  output logic [1:0] state,
  output logic [3:0] left_score,
  output logic [3:0] right_score,
  output logic       ball_enable,
  output logic       serve,
  output logic       serve_dir,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SERVE = 2'b01,
    ST_PLAY  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [3:0] WIN_Q = 4'(WIN_SCORE);
  localparam logic [7:0] DELAY = 8'(SERVE_DELAY);

  state_t     state_q, state_d;
  logic [3:0] left_q, left_d, right_q, right_d;
  logic [1:0] winner_q, winner_d;
  logic       dir_q, dir_d;
  logic [7:0] cnt_q, cnt_d;
  logic       start_prev_q;

  logic       start_rise;
  logic       serve_fire;
  logic [3:0] left_inc, right_inc;

  assign start_rise = start & ~start_prev_q;
  // An abort (start low) in the final serve cycle suppresses the launch.
  assign serve_fire = (state_q == ST_SERVE) & start & game_tick & (cnt_q == 8'd1);
  assign left_inc   = (left_q  == 4'hF) ? left_q  : left_q  + 4'd1;
  assign right_inc  = (right_q == 4'hF) ? right_q : right_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    left_d   = left_q;
    right_d  = right_q;
    winner_d = winner_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          left_d   = 4'd0;
          right_d  = 4'd0;
          winner_d = 2'b00;
          dir_d    = 1'b0;
          cnt_d    = DELAY;
          state_d  = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (!start) begin
          state_d = ST_IDLE;
        end else if (game_tick && (cnt_q != 8'd0)) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (!start) begin
          state_d = ST_IDLE;
        end else if (point_left && point_right) begin
          state_d = ST_SERVE;
          cnt_d   = DELAY;
        end else if (point_left) begin
          left_d = left_inc;
          dir_d  = 1'b1;
          if (left_inc == WIN_Q) begin
            state_d  = ST_DONE;
            winner_d = 2'b01;
          end else begin
            state_d = ST_SERVE;
            cnt_d   = DELAY;
          end
        end else if (point_right) begin
          right_d = right_inc;
          dir_d   = 1'b0;
          if (right_inc == WIN_Q) begin
            state_d  = ST_DONE;
            winner_d = 2'b10;
          end else begin
            state_d = ST_SERVE;
            cnt_d   = DELAY;
          end
        end
      end
      ST_DONE: begin
        if (!start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // start_prev resets high so a switch already on at reset release is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      left_q       <= 4'd0;
      right_q      <= 4'd0;
      winner_q     <= 2'b00;
      dir_q        <= 1'b0;
      cnt_q        <= 8'd0;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      left_q       <= left_d;
      right_q      <= right_d;
      winner_q     <= winner_d;
      dir_q        <= dir_d;
      cnt_q        <= cnt_d;
      start_prev_q <= start;
    end
  end

  assign state       = state_q;
  assign left_score  = left_q;
  assign right_score = right_q;
  assign winner      = winner_q;
  assign serve_dir   = dir_q;
  assign ball_enable = (state_q == ST_PLAY);
  assign serve       = serve_fire;

endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench for match_controller: stimulus queues each expected output change,
// a negedge monitor pops and compares whenever the DUT's observable outputs change.
`timescale 1ns/1ps
module tb_match_controller;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_SERVE = 2'b01;
  localparam logic [1:0] S_PLAY  = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] ls;
    logic [3:0] rs;
    logic       dir;
    logic [1:0] win;
    logic       be;
    logic       sv;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, game_tick, point_left, point_right;
  logic [1:0] state, winner;
  logic [3:0] left_score, right_score;
  logic       ball_enable, serve, serve_dir;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];
  obs_t e;
  obs_t last_pushed;
  bit   pushed_any = 0;

  always #5 clk = ~clk;

  match_controller #(.WIN_SCORE(10), .SERVE_DELAY(3)) dut (
    .clk(clk), .reset(reset), .start(start), .game_tick(game_tick),
    .point_left(point_left), .point_right(point_right), .state(state),
    .left_score(left_score), .right_score(right_score), .ball_enable(ball_enable),
    .serve(serve), .serve_dir(serve_dir), .winner(winner)
  );

  task automatic push_exp();
    e.be = (e.st == S_PLAY);
    if (!pushed_any || e !== last_pushed) begin
      exp_q.push_back(e);
      last_pushed = e;
      pushed_any  = 1;
    end
  endtask

  // Drive one clock of inputs; e holds the outputs expected at this cycle's negedge.
  task automatic step(input logic s, input logic g, input logic l, input logic r);
    start = s; game_tick = g; point_left = l; point_right = r;
    push_exp();
    @(posedge clk); #1;
    game_tick = 0; point_left = 0; point_right = 0;
  endtask

  // Three ticks from a freshly loaded counter; stray points during SERVE must be ignored.
  task automatic serve_seq();
    step(1, 1, 1, 0);
    step(1, 1, 0, 1);
    e.sv = 1'b1;
    step(1, 1, 0, 0);
    e.sv = 1'b0;
    e.st = S_PLAY;
  endtask

  initial begin : monitor
    obs_t cur, prev, exp_v;
    bit   first = 1;
    forever begin
      @(negedge clk);
      cur = {state, left_score, right_score, serve_dir, winner, ball_enable, serve};
      if (first || cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got st=%b l=%0d r=%0d dir=%b win=%b be=%b sv=%b required none",
                   cur.st, cur.ls, cur.rs, cur.dir, cur.win, cur.be, cur.sv);
        end else begin
          exp_v = exp_q.pop_front();
          if (cur !== exp_v) begin
            errors++;
            $display("FAIL output_event got st=%b l=%0d r=%0d dir=%b win=%b be=%b sv=%b required st=%b l=%0d r=%0d dir=%b win=%b be=%b sv=%b",
                     cur.st, cur.ls, cur.rs, cur.dir, cur.win, cur.be, cur.sv,
                     exp_v.st, exp_v.ls, exp_v.rs, exp_v.dir, exp_v.win, exp_v.be, exp_v.sv);
          end else begin
            $display("event %0d t=%0t st=%b l=%0d r=%0d dir=%b win=%b be=%b sv=%b ok",
                     checks, $time, cur.st, cur.ls, cur.rs, cur.dir, cur.win, cur.be, cur.sv);
          end
        end
        prev  = cur;
        first = 0;
      end
    end
  end

  initial begin : stimulus
    logic [14:0] got;
    reset = 0; start = 0; game_tick = 0; point_left = 0; point_right = 0;
    e = '0;
    push_exp();
    repeat (2) @(posedge clk);
    #1 reset = 1;

    // ticks in IDLE are ignored; then a start edge
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    e.st = S_SERVE;
    serve_seq();

    // left point, then right point after next serve
    step(1, 0, 1, 0);
    e.ls = 4'd1; e.dir = 1'b1; e.st = S_SERVE;
    serve_seq();
    step(1, 0, 0, 1);
    e.rs = 4'd1; e.dir = 1'b0; e.st = S_SERVE;
    serve_seq();
    step(1, 0, 1, 0);
    e.ls = 4'd2; e.dir = 1'b1; e.st = S_SERVE;

    // let: both strobes together, no score change, direction kept
    serve_seq();
    step(1, 0, 1, 1);
    e.st = S_SERVE;

    // left runs up to the winning score
    while (e.ls < 4'd10) begin
      serve_seq();
      step(1, 0, 1, 0);
      e.ls  = e.ls + 4'd1;
      e.dir = 1'b1;
      if (e.ls == 4'd10) begin
        e.st = S_DONE; e.win = 2'b01;
      end else begin
        e.st = S_SERVE;
      end
    end

    // DONE ignores points and ticks while start stays high
    step(1, 1, 1, 0);
    step(1, 0, 0, 1);
    step(0, 0, 0, 0);
    e.st = S_IDLE;
    step(0, 0, 0, 0);

    // fresh start clears scores and winner
    step(1, 0, 0, 0);
    e = '0; e.st = S_SERVE;
    serve_seq();
    step(1, 0, 0, 1);
    e.rs = 4'd1; e.dir = 1'b0; e.st = S_SERVE;

    // abort on the would-be serve tick: no pulse, scores hold
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    e.st = S_IDLE;
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    e = '0; e.st = S_SERVE;

    for (int i = 0; i < 5; i++) begin
      serve_seq();
      step(1, 0, 1, 0);
      e.ls = e.ls + 4'd1; e.dir = 1'b1; e.st = S_SERVE;
    end
    serve_seq();
    step(1, 0, 0, 0);

    // asynchronous reset mid-PLAY with left_score=5
    reset = 0;
    #2;
    got = {state, left_score, right_score, serve_dir, winner, ball_enable, serve};
    checks++;
    if (got !== 15'd0) begin
      errors++;
      $display("FAIL async_reset got %b required %b", got, 15'd0);
    end else begin
      $display("async_reset t=%0t outputs cleared ok", $time);
    end
    e = '0;
    push_exp();
    @(posedge clk); #1;
    reset = 1;
    // start held high across reset release must not begin a match
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
